// File: rtl/kernel_bram_pingpong_ctrl.sv
// Ping-pong kernel BRAM controller: AXIS kernel load into the write bank while the
// conv datapath walks the read bank channel by channel.
module kernel_bram_pingpong_ctrl #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_channel_size,
  input  logic              load_start,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              rd_advance,
  input  logic              swap,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W:0]   bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W:0]   bram_addrb,
  output logic              load_busy,
  output logic              load_done,
  output logic              wr_full,
  output logic              rd_valid,
  output logic              last_channel,
  output logic              swap_ack,
  output logic              tlast_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] ch_size_wr_q, ch_size_wr_d;
  logic [ADDR_W-1:0] ch_size_rd_q, ch_size_rd_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_full_q, wr_full_d;
  logic              rd_valid_q, rd_valid_d;
  logic              tlast_err_q, tlast_err_d;
  logic              last_channel_q, last_channel_d;
  logic              swap_ack_q, swap_ack_d;

  logic beat, final_beat, swap_acc, load_acc;

  always_comb begin
    beat       = (state_q == S_LOAD) && s_axis_tvalid;
    final_beat = (wr_cnt_q == ch_size_wr_q - ADDR_W'(1));
    swap_acc   = swap && wr_full_q && (state_q == S_IDLE);
    // A swap in the same cycle frees the write bank, so the load may start alongside it.
    load_acc   = load_start && (state_q == S_IDLE) && (cfg_channel_size != '0) &&
                 (!wr_full_q || swap_acc);

    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    ch_size_wr_d   = ch_size_wr_q;
    ch_size_rd_d   = ch_size_rd_q;
    rd_bank_d      = rd_bank_q;
    wr_full_d      = wr_full_q;
    rd_valid_d     = rd_valid_q;
    tlast_err_d    = tlast_err_q;
    last_channel_d = 1'b0;
    swap_ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_acc) begin
          state_d      = S_LOAD;
          ch_size_wr_d = cfg_channel_size;
          wr_cnt_d     = '0;
          tlast_err_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          if (s_axis_tlast != final_beat) tlast_err_d = 1'b1;
          if (final_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        wr_full_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (swap_acc) begin
      rd_bank_d    = ~rd_bank_q;
      ch_size_rd_d = ch_size_wr_q;
      rd_cnt_d     = '0;
      wr_full_d    = 1'b0;
      rd_valid_d   = 1'b1;
      swap_ack_d   = 1'b1;
    end else if (rd_valid_q && rd_advance) begin
      if (rd_cnt_q == ch_size_rd_q - ADDR_W'(1)) begin
        rd_cnt_d       = '0;
        last_channel_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      ch_size_wr_q   <= '0;
      ch_size_rd_q   <= '0;
      rd_bank_q      <= 1'b0;
      wr_full_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      tlast_err_q    <= 1'b0;
      last_channel_q <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      ch_size_wr_q   <= ch_size_wr_d;
      ch_size_rd_q   <= ch_size_rd_d;
      rd_bank_q      <= rd_bank_d;
      wr_full_q      <= wr_full_d;
      rd_valid_q     <= rd_valid_d;
      tlast_err_q    <= tlast_err_d;
      last_channel_q <= last_channel_d;
      swap_ack_q     <= swap_ack_d;
    end
  end

  assign s_axis_tready = (state_q == S_LOAD);
  assign bram_ena      = beat;
  assign bram_wea      = beat;
  assign bram_addra    = {~rd_bank_q, wr_cnt_q};
  assign bram_dina     = s_axis_tdata;
  assign bram_enb      = ~rst;
  assign bram_addrb    = {rd_bank_q, rd_cnt_q};
  assign load_busy     = (state_q != S_IDLE);
  assign load_done     = (state_q == S_DONE);
  assign wr_full       = wr_full_q;
  assign rd_valid      = rd_valid_q;
  assign last_channel  = last_channel_q;
  assign swap_ack      = swap_ack_q;
  assign tlast_err     = tlast_err_q;

endmodule

// File: tb/tb_kernel_bram_pingpong_ctrl.sv
// Self-checking bench for kernel_bram_pingpong_ctrl: vector table, directed corner
// sequences and randomized traffic against an abstract bank/beat model.
module tb_kernel_bram_pingpong_ctrl;
  localparam int DATA_W = 72;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] cfg_channel_size = '0;
  logic              load_start = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              rd_advance = 1'b0;
  logic              swap = 1'b0;
  logic              bram_ena, bram_wea, bram_enb;
  logic [ADDR_W:0]   bram_addra, bram_addrb;
  logic [DATA_W-1:0] bram_dina;
  logic              load_busy, load_done, wr_full, rd_valid, last_channel, swap_ack, tlast_err;

  int n_pass = 0;
  int n_total = 0;

  kernel_bram_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_channel_size(cfg_channel_size), .load_start(load_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .rd_advance(rd_advance), .swap(swap),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .load_busy(load_busy), .load_done(load_done),
    .wr_full(wr_full), .rd_valid(rd_valid), .last_channel(last_channel), .swap_ack(swap_ack),
    .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs are applied on the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic ls, input logic [ADDR_W-1:0] cfg, input logic tv,
                      input logic [DATA_W-1:0] td, input logic tl, input logic sw, input logic ra);
    @(negedge clk);
    load_start = ls; cfg_channel_size = cfg; s_axis_tvalid = tv; s_axis_tdata = td;
    s_axis_tlast = tl; swap = sw; rd_advance = ra;
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic ls; logic [ADDR_W-1:0] cfg; logic tv; logic [DATA_W-1:0] td; logic tl; logic sw; logic ra;
    logic e_tready; logic e_wea; logic [ADDR_W:0] e_addra; logic e_done; logic e_wf; logic e_sa;
    logic [ADDR_W:0] e_addrb; logic e_lc; logic e_te; logic e_rv;
  } vec_t;
  vec_t tbl[16];

  // Abstract reference: beats remaining in the current load, bank indices, pending pulses.
  int m_rd_bank, m_wr_full, m_rd_valid, m_beats_left, m_done, m_te, m_lc, m_sa;
  int m_wr_idx, m_rd_idx, m_size_wr, m_size_rd;

  task automatic model_reset();
    m_rd_bank = 0; m_wr_full = 0; m_rd_valid = 0; m_beats_left = 0; m_done = 0; m_te = 0;
    m_lc = 0; m_sa = 0; m_wr_idx = 0; m_rd_idx = 0; m_size_wr = 0; m_size_rd = 0;
  endtask

  task automatic model_check(input int cyc);
    bit busy, exp_wea;
    busy    = (m_beats_left > 0) || (m_done != 0);
    exp_wea = (m_beats_left > 0) && s_axis_tvalid;
    chk($sformatf("rnd%0d tready", cyc), 96'(s_axis_tready), 96'(m_beats_left > 0));
    chk($sformatf("rnd%0d wea", cyc), 96'(bram_wea), 96'(exp_wea));
    chk($sformatf("rnd%0d ena", cyc), 96'(bram_ena), 96'(exp_wea));
    if (exp_wea) begin
      chk($sformatf("rnd%0d addra", cyc), 96'(bram_addra), 96'((1 - m_rd_bank) * 512 + m_wr_idx));
      chk($sformatf("rnd%0d dina", cyc), 96'(bram_dina), 96'(s_axis_tdata));
    end
    chk($sformatf("rnd%0d addrb", cyc), 96'(bram_addrb), 96'(m_rd_bank * 512 + m_rd_idx));
    chk($sformatf("rnd%0d enb", cyc), 96'(bram_enb), 96'(1));
    chk($sformatf("rnd%0d busy", cyc), 96'(load_busy), 96'(busy));
    chk($sformatf("rnd%0d done", cyc), 96'(load_done), 96'(m_done));
    chk($sformatf("rnd%0d wr_full", cyc), 96'(wr_full), 96'(m_wr_full));
    chk($sformatf("rnd%0d rd_valid", cyc), 96'(rd_valid), 96'(m_rd_valid));
    chk($sformatf("rnd%0d last_ch", cyc), 96'(last_channel), 96'(m_lc));
    chk($sformatf("rnd%0d swap_ack", cyc), 96'(swap_ack), 96'(m_sa));
    chk($sformatf("rnd%0d tlast_err", cyc), 96'(tlast_err), 96'(m_te));
  endtask

  task automatic model_update();
    bit busy, swap_ok, load_ok;
    busy    = (m_beats_left > 0) || (m_done != 0);
    swap_ok = swap && (m_wr_full != 0) && !busy;
    load_ok = load_start && !busy && (cfg_channel_size != 0) && ((m_wr_full == 0) || swap_ok);
    m_lc = 0; m_sa = 0;
    if (m_done != 0) begin
      m_done = 0; m_wr_full = 1;
    end else if (m_beats_left > 0 && s_axis_tvalid) begin
      if (s_axis_tlast != (m_beats_left == 1)) m_te = 1;
      m_wr_idx++; m_beats_left--;
      if (m_beats_left == 0) m_done = 1;
    end
    if (swap_ok) begin
      m_rd_bank = 1 - m_rd_bank; m_size_rd = m_size_wr; m_rd_idx = 0;
      m_wr_full = 0; m_rd_valid = 1; m_sa = 1;
    end else if (m_rd_valid != 0 && rd_advance) begin
      m_rd_idx = (m_rd_idx + 1) % m_size_rd;
      if (m_rd_idx == 0) m_lc = 1;
    end
    if (load_ok) begin
      m_size_wr = int'(cfg_channel_size); m_wr_idx = 0; m_te = 0; m_beats_left = m_size_wr;
    end
  endtask

  initial begin
    int wcnt;
    // ls cfg tv td tl sw ra | tready wea addra done wf sa addrb lc te rv
    tbl[0]  = '{1'b1, 9'd4, 1'b0, 72'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 9'd0, 1'b1, 72'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 9'd0, 1'b1, 72'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h201, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 9'd0, 1'b0, 72'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h202, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 9'd0, 1'b1, 72'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h202, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 9'd0, 1'b1, 72'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h203, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h201, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h202, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h203, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h200, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("rst tready", 96'(s_axis_tready), 96'(0));
    chk("rst wea", 96'(bram_wea), 96'(0));
    chk("rst enb", 96'(bram_enb), 96'(0));
    chk("rst addrb", 96'(bram_addrb), 96'(0));
    chk("rst wr_full", 96'(wr_full), 96'(0));
    chk("rst rd_valid", 96'(rd_valid), 96'(0));
    chk("rst tlast_err", 96'(tlast_err), 96'(0));
    do_reset();
    idle();
    chk("post-rst enb", 96'(bram_enb), 96'(1));
    chk("post-rst addra", 96'(bram_addra), 96'(10'h200));
    chk("post-rst busy", 96'(load_busy), 96'(0));

    // Asynchronous reset mid-load, after 3 of 8 beats
    step(1'b1, 9'd8, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 72'(i), 1'b0, 1'b0, 1'b0);
    idle();
    chk("midrst pre tready", 96'(s_axis_tready), 96'(1));
    rst = 1'b1;
    #1;
    chk("midrst tready", 96'(s_axis_tready), 96'(0));
    chk("midrst wr_full", 96'(wr_full), 96'(0));
    chk("midrst rd_bank", 96'(bram_addrb[ADDR_W]), 96'(0));
    chk("midrst busy", 96'(load_busy), 96'(0));
    #1 rst = 1'b0;
    step(1'b1, 9'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 72'h55, 1'b0, 1'b0, 1'b0);
    chk("midrst reload wea", 96'(bram_wea), 96'(1));
    chk("midrst reload addra", 96'(bram_addra), 96'(10'h200));
    step(1'b0, '0, 1'b1, 72'h56, 1'b1, 1'b0, 1'b0);
    chk("midrst reload addra1", 96'(bram_addra), 96'(10'h201));
    idle();
    chk("midrst reload done", 96'(load_done), 96'(1));

    // Vector table: load with gap, swap, read-address wrap, ignored requests
    do_reset();
    for (int r = 0; r < 16; r++) begin
      step(tbl[r].ls, tbl[r].cfg, tbl[r].tv, tbl[r].td, tbl[r].tl, tbl[r].sw, tbl[r].ra);
      chk($sformatf("v%0d tready", r), 96'(s_axis_tready), 96'(tbl[r].e_tready));
      chk($sformatf("v%0d wea", r), 96'(bram_wea), 96'(tbl[r].e_wea));
      if (tbl[r].e_wea) begin
        chk($sformatf("v%0d addra", r), 96'(bram_addra), 96'(tbl[r].e_addra));
        chk($sformatf("v%0d dina", r), 96'(bram_dina), 96'(tbl[r].td));
      end
      chk($sformatf("v%0d done", r), 96'(load_done), 96'(tbl[r].e_done));
      chk($sformatf("v%0d wr_full", r), 96'(wr_full), 96'(tbl[r].e_wf));
      chk($sformatf("v%0d swap_ack", r), 96'(swap_ack), 96'(tbl[r].e_sa));
      chk($sformatf("v%0d addrb", r), 96'(bram_addrb), 96'(tbl[r].e_addrb));
      chk($sformatf("v%0d last_ch", r), 96'(last_channel), 96'(tbl[r].e_lc));
      chk($sformatf("v%0d tlast_err", r), 96'(tlast_err), 96'(tbl[r].e_te));
      chk($sformatf("v%0d rd_valid", r), 96'(rd_valid), 96'(tbl[r].e_rv));
    end

    // rd_bank=1, ch_size_rd=4: load 3 words into bank 0, then swap with rd_advance
    step(1'b1, 9'd3, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 72'(100 + i), 1'(i == 2), 1'b0, 1'b0);
      chk($sformatf("b0 addra%0d", i), 96'(bram_addra), 96'(i));
      chk($sformatf("b0 addrb%0d", i), 96'(bram_addrb), 96'(10'h200));
    end
    idle();
    idle();
    chk("b0 wr_full", 96'(wr_full), 96'(1));
    step(1'b1, 9'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("full ignore tready", 96'(s_axis_tready), 96'(0));
    chk("full ignore busy", 96'(load_busy), 96'(0));
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("swapadv pre addrb", 96'(bram_addrb), 96'(10'h201));
    idle();
    chk("swapadv addrb", 96'(bram_addrb), 96'(10'h000));
    chk("swapadv last_ch", 96'(last_channel), 96'(0));
    chk("swapadv ack", 96'(swap_ack), 96'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("wrap3 lc%0d", i), 96'(last_channel), 96'(0));
      chk($sformatf("wrap3 addrb%0d", i), 96'(bram_addrb), 96'(i));
    end
    idle();
    chk("wrap3 last_ch", 96'(last_channel), 96'(1));
    chk("wrap3 addrb", 96'(bram_addrb), 96'(0));

    // tlast on beat 1 of 4: still four writes, sticky error, cleared by next accepted load
    step(1'b1, 9'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 72'(200 + i), 1'(i == 1), 1'b0, 1'b0);
      if (bram_wea) wcnt++;
    end
    idle();
    chk("terr writes", 96'(wcnt), 96'(4));
    chk("terr done", 96'(load_done), 96'(1));
    chk("terr flag", 96'(tlast_err), 96'(1));
    repeat (3) idle();
    chk("terr sticky", 96'(tlast_err), 96'(1));
    step(1'b1, 9'd2, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("swapload ack", 96'(swap_ack), 96'(1));
    chk("swapload addrb", 96'(bram_addrb), 96'(10'h200));
    chk("swapload tready", 96'(s_axis_tready), 96'(1));
    chk("swapload terr clr", 96'(tlast_err), 96'(0));
    step(1'b0, '0, 1'b1, 72'h77, 1'b0, 1'b0, 1'b0);
    chk("swapload addra", 96'(bram_addra), 96'(10'h000));
    step(1'b0, '0, 1'b1, 72'h78, 1'b1, 1'b0, 1'b0);
    idle();
    chk("swapload done", 96'(load_done), 96'(1));
    chk("swapload terr", 96'(tlast_err), 96'(0));

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [95:0] rnd;
      logic tl;
      rnd = {$urandom, $urandom, $urandom};
      if (m_beats_left > 0) tl = 1'((m_beats_left == 1) ^ ($urandom_range(11) == 0));
      else tl = 1'($urandom_range(1));
      step(1'($urandom_range(3) == 0),
           ($urandom_range(7) == 0) ? 9'd0 : 9'($urandom_range(5, 1)),
           1'($urandom_range(9) < 7), rnd[DATA_W-1:0], tl,
           1'($urandom_range(4) == 0), 1'($urandom_range(1)));
      model_check(c);
      model_update();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
